instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Instruction-side responder to the processor controller's fetch control outputs (PC_clr, PC_up, IR_ld).
- Holds the program counter, the instruction memory and the instruction register (IR).
- The IR drives the controller's instruction input.
- A program-load write port lets the bench or a loader fill instruction memory before execution.

Parameters:
- PC_WIDTH, 7, program counter and instruction memory address width.
- INSTR_WIDTH, 16, instruction word width.
- MEM_DEPTH, 128, number of instruction words. Must equal 2**PC_WIDTH.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- PC_clr  input  1  synchronous clear of PC, IR and fetch count.
- PC_up  input  1  increment PC.
- IR_ld  input  1  load IR from instruction memory at the current PC.
- prog_we  input  1  instruction memory write enable.
- prog_addr  input  PC_WIDTH  instruction memory write address.
- prog_data  input  INSTR_WIDTH  instruction memory write data.
- instruction  output  INSTR_WIDTH  IR contents, feeds the controller.
- PC  output  PC_WIDTH  current program counter.
- pc_wrap  output  1  one-cycle pulse: PC wrapped from MEM_DEPTH-1 to 0.
- fetch_count  output  16  number of IR loads since reset/clear; saturating.

Behaviour:
- Reset (asynchronous, active-high), effective immediately, including mid-operation:
  - PC = 0, instruction = 16'h0000 (NOOP encoding), pc_wrap = 0, fetch_count = 0.
  - Memory contents are NOT cleared. prog_we is ignored while reset is high.
- Instruction memory:
  - MEM_DEPTH x INSTR_WIDTH array with combinational read of mem[PC].
  - Synchronous write: mem[prog_addr] <= prog_data on a clk edge when prog_we = 1.
- Update priority per edge: reset > PC_clr > PC_up for PC.
- PC_clr = 1:
  - PC <= 0, instruction <= 0, fetch_count <= 0, pc_wrap <= 0.
  - PC_up and IR_ld are ignored that cycle.
  - Memory writes still occur.
- PC_up = 1 (no clear): PC <= PC + 1 modulo MEM_DEPTH.
  - At PC = MEM_DEPTH-1: PC <= 0 and pc_wrap <= 1 for exactly one cycle.
  - Otherwise pc_wrap <= 0.
- IR_ld = 1 (no clear):
  - instruction <= mem[PC], using PC before any same-edge increment.
  - fetch_count <= fetch_count + 1, saturating at 16'hFFFF.
- PC_up and IR_ld together, the controller's FETCH case: IR captures the word at the old PC and PC advances, in the same edge.
- Write/read collision (prog_we with prog_addr == PC, same edge as IR_ld): IR captures the OLD memory word. The new word is visible from the next cycle.
- Latency:
  - PC, instruction, pc_wrap and fetch_count change only on clk edges or reset; they are registered outputs.
  - instruction reflects a load one edge after IR_ld is sampled high.
- With no control input asserted, all registers hold.
- No internal FSM beyond these registers. Sequencing is owned by the controller; this block is purely responsive.

Test Plan:
- Program and fetch: load mem[0..2] = 16'h2105, 16'h3120, 16'h5000 via prog_we; reset; pulse PC_up+IR_ld three times -> instruction = 2105, 3120, 5000 after successive edges; PC = 1, 2, 3; fetch_count = 3.
- Wrap: PC_up held for 128 edges from PC = 0 -> PC returns to 0; pc_wrap high for exactly the one cycle after the 127->0 edge.
- Clear priority: PC = 5, instruction = 3120, assert PC_clr with PC_up and IR_ld -> next edge PC = 0, instruction = 0000, fetch_count = 0.
- Collision: PC = 4, mem[4] = 16'h1111; same edge IR_ld = 1, prog_we = 1, prog_addr = 4, prog_data = 16'h2222 -> instruction = 1111; following IR_ld -> 2222.
- Async reset mid-run: assert reset between clock edges with PC = 9 -> PC = 0, instruction = 0 without waiting for an edge; mem[9] unchanged after deassert.
- Saturation: force 65535 IR loads, then one more IR_ld -> fetch_count stays 16'hFFFF.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// PC, instruction memory and IR answering the controller's PC_clr/PC_up/IR_ld strobes.
// Latency: registered outputs, IR valid one edge after IR_ld; backpressure: none, every strobe is honoured on its edge.
module instr_fetch_unit #(
    parameter int PC_WIDTH    = 7,
    parameter int INSTR_WIDTH = 16,
    parameter int MEM_DEPTH   = 128
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   PC_clr,
    input  logic                   PC_up,
    input  logic                   IR_ld,
    input  logic                   prog_we,
    input  logic [PC_WIDTH-1:0]    prog_addr,
    input  logic [INSTR_WIDTH-1:0] prog_data,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic [PC_WIDTH-1:0]    PC,
    output logic                   pc_wrap,
    output logic [15:0]            fetch_count
);

    logic [INSTR_WIDTH-1:0] mem_q [MEM_DEPTH];
    logic [INSTR_WIDTH-1:0] rd_word;

    logic [PC_WIDTH-1:0]    pc_q,   pc_d;
    logic [INSTR_WIDTH-1:0] ir_q,   ir_d;
    logic                   wrap_q, wrap_d;
    logic [15:0]            fcnt_q, fcnt_d;

    // Read sees the pre-edge contents, so a same-edge write to mem[PC] lands one cycle later.
    assign rd_word = mem_q[pc_q];

    always_comb begin
        pc_d   = pc_q;
        ir_d   = ir_q;
        wrap_d = 1'b0;
        fcnt_d = fcnt_q;
        if (PC_clr) begin
            pc_d   = '0;
            ir_d   = '0;
            fcnt_d = '0;
        end else begin
            // PC_WIDTH bits wrap naturally because MEM_DEPTH is 2**PC_WIDTH.
            if (PC_up) begin
                pc_d   = pc_q + 1'b1;
                wrap_d = (pc_q == PC_WIDTH'(MEM_DEPTH - 1));
            end
            if (IR_ld) begin
                ir_d = rd_word;
                if (fcnt_q != 16'hFFFF) begin
                    fcnt_d = fcnt_q + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q   <= '0;
            ir_q   <= '0;
            wrap_q <= 1'b0;
            fcnt_q <= '0;
        end else begin
            pc_q   <= pc_d;
            ir_q   <= ir_d;
            wrap_q <= wrap_d;
            fcnt_q <= fcnt_d;
        end
    end

    // Program contents survive reset; the loader is simply locked out while reset is high.
    always_ff @(posedge clk) begin
        if (prog_we && !reset) begin
            mem_q[prog_addr] <= prog_data;
        end
    end

    assign instruction = ir_q;
    assign PC          = pc_q;
    assign pc_wrap     = wrap_q;
    assign fetch_count = fcnt_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: expected register state is queued as each step is driven
// and popped for comparison one edge later.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        PC_clr = 1'b0;
    logic        PC_up = 1'b0;
    logic        IR_ld = 1'b0;
    logic        prog_we = 1'b0;
    logic [6:0]  prog_addr = '0;
    logic [15:0] prog_data = '0;
    logic [15:0] instruction;
    logic [6:0]  PC;
    logic        pc_wrap;
    logic [15:0] fetch_count;

    instr_fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .PC_clr      (PC_clr),
        .PC_up       (PC_up),
        .IR_ld       (IR_ld),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .instruction (instruction),
        .PC          (PC),
        .pc_wrap     (pc_wrap),
        .fetch_count (fetch_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] instr;
        logic [6:0]  pc;
        logic        wrap;
        logic [15:0] fcnt;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic expect_state(input logic [15:0] ei, input logic [6:0] ep, input logic ew,
                                input logic [15:0] ef, input string tag);
        exp_t e;
        e.instr = ei;
        e.pc    = ep;
        e.wrap  = ew;
        e.fcnt  = ef;
        e.tag   = tag;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        n_cmp++;
        assert (sb.size() > 0) else begin
            n_bad++;
            $error("FAIL scoreboard_empty: observed %0d entries expected >0", sb.size());
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({e.tag, ".instr"}, instruction, e.instr);
            chk({e.tag, ".pc"},    {9'd0, PC}, {9'd0, e.pc});
            chk({e.tag, ".wrap"},  {15'd0, pc_wrap}, {15'd0, e.wrap});
            chk({e.tag, ".fcnt"},  fetch_count, e.fcnt);
        end
    endtask

    // Drive one cycle of control/program inputs, queue the expected post-edge state, check it at edge+1.
    task automatic step(input logic clr, input logic up, input logic ld, input logic we,
                        input logic [6:0] a, input logic [15:0] d,
                        input logic [15:0] ei, input logic [6:0] ep, input logic ew,
                        input logic [15:0] ef, input string tag);
        PC_clr = clr; PC_up = up; IR_ld = ld;
        prog_we = we; prog_addr = a; prog_data = d;
        expect_state(ei, ep, ew, ef, tag);
        @(posedge clk);
        #1;
        PC_clr = 1'b0; PC_up = 1'b0; IR_ld = 1'b0; prog_we = 1'b0;
        check_out();
    endtask

    task automatic prog(input logic [6:0] a, input logic [15:0] d);
        step(1'b0, 1'b0, 1'b0, 1'b1, a, d, 16'h0000, 7'd0, 1'b0, 16'd0, "prog_hold");
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        expect_state(16'h0000, 7'd0, 1'b0, 16'd0, "reset_state");
        check_out();
        reset = 1'b0;

        prog(7'd0,  16'h2105);
        prog(7'd1,  16'h3120);
        prog(7'd2,  16'h5000);
        prog(7'd3,  16'h7777);
        prog(7'd4,  16'h1111);
        prog(7'd5,  16'h3120);
        prog(7'd9,  16'hABCD);

        // A write attempted under reset must not reach memory.
        reset = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b1, 7'd3, 16'hDEAD, 16'h0000, 7'd0, 1'b0, 16'd0, "we_in_reset");
        reset = 1'b0;

        step(1'b0, 1'b1, 1'b1, 1'b0, 7'd0, 16'h0, 16'h2105, 7'd1, 1'b0, 16'd1, "fetch0");
        step(1'b0, 1'b1, 1'b1, 1'b0, 7'd0, 16'h0, 16'h3120, 7'd2, 1'b0, 16'd2, "fetch1");
        step(1'b0, 1'b1, 1'b1, 1'b0, 7'd0, 16'h0, 16'h5000, 7'd3, 1'b0, 16'd3, "fetch2");
        step(1'b0, 1'b0, 1'b1, 1'b0, 7'd0, 16'h0, 16'h7777, 7'd3, 1'b0, 16'd4, "ld_only_pc3");
        step(1'b0, 1'b1, 1'b0, 1'b0, 7'd0, 16'h0, 16'h7777, 7'd4, 1'b0, 16'd4, "up_only");

        step(1'b0, 1'b0, 1'b1, 1'b1, 7'd4, 16'h2222, 16'h1111, 7'd4, 1'b0, 16'd5, "collision_old");
        step(1'b0, 1'b0, 1'b1, 1'b0, 7'd0, 16'h0,    16'h2222, 7'd4, 1'b0, 16'd6, "collision_new");
        step(1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 16'h0,    16'h2222, 7'd4, 1'b0, 16'd6, "idle_hold");
        step(1'b0, 1'b1, 1'b0, 1'b0, 7'd0, 16'h0,    16'h2222, 7'd5, 1'b0, 16'd6, "to_pc5");
        step(1'b0, 1'b0, 1'b1, 1'b0, 7'd0, 16'h0,    16'h3120, 7'd5, 1'b0, 16'd7, "ld_pc5");
        step(1'b1, 1'b1, 1'b1, 1'b1, 7'd10, 16'h0BEE, 16'h0000, 7'd0, 1'b0, 16'd0, "clr_priority");

        for (int i = 0; i < 9; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 7'd0, 16'h0, 16'h0000, 7'(i + 1), 1'b0, 16'd0, "walk_to_9");
        end
        step(1'b0, 1'b0, 1'b1, 1'b0, 7'd0, 16'h0, 16'hABCD, 7'd9, 1'b0, 16'd1, "ld_pc9");

        // Reset raised between edges must take effect before the next edge.
        #2 reset = 1'b1;
        #1;
        expect_state(16'h0000, 7'd0, 1'b0, 16'd0, "async_reset");
        check_out();
        #2 reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 7'd0, 16'h0, 16'h0000, 7'(i + 1), 1'b0, 16'd0, "rewalk_to_9");
        end
        step(1'b0, 1'b0, 1'b1, 1'b0, 7'd0, 16'h0, 16'hABCD, 7'd9,  1'b0, 16'd1, "mem9_kept");
        step(1'b0, 1'b1, 1'b0, 1'b0, 7'd0, 16'h0, 16'hABCD, 7'd10, 1'b0, 16'd1, "to_pc10");
        step(1'b0, 1'b0, 1'b1, 1'b0, 7'd0, 16'h0, 16'h0BEE, 7'd10, 1'b0, 16'd2, "write_during_clr");

        step(1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 16'h0, 16'h0000, 7'd0, 1'b0, 16'd0, "clr_before_wrap");
        for (int i = 0; i < 128; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 7'd0, 16'h0, 16'h0000, 7'((i + 1) % 128),
                 (i == 127), 16'd0, "wrap_walk");
        end
        step(1'b0, 1'b1, 1'b0, 1'b0, 7'd0, 16'h0, 16'h0000, 7'd1, 1'b0, 16'd0, "wrap_pulse_end");
        step(1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 16'h0, 16'h0000, 7'd1, 1'b0, 16'd0, "post_wrap_idle");

        step(1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 16'h0, 16'h0000, 7'd0, 1'b0, 16'd0, "clr_before_sat");
        IR_ld = 1'b1;
        repeat (65534) @(posedge clk);
        #1;
        IR_ld = 1'b0;
        expect_state(16'h2105, 7'd0, 1'b0, 16'hFFFE, "count_65534");
        check_out();
        step(1'b0, 1'b0, 1'b1, 1'b0, 7'd0, 16'h0, 16'h2105, 7'd0, 1'b0, 16'hFFFF, "count_reach_max");
        step(1'b0, 1'b0, 1'b1, 1'b0, 7'd0, 16'h0, 16'h2105, 7'd0, 1'b0, 16'hFFFF, "count_saturate");
        step(1'b0, 1'b1, 1'b1, 1'b0, 7'd0, 16'h0, 16'h2105, 7'd1, 1'b0, 16'hFFFF, "count_saturate2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
